// File: rtl/fir_ser_pkg.sv
// Shared definitions for the FIR sample serial link (serializer and deserializer).
// State encoding and default link parameters.
package fir_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } ser_state_e;

    localparam int unsigned DEF_BW      = 9;
    localparam int unsigned DEF_CLK_DIV = 1;
    localparam int unsigned DEF_GAP_CYC = 2;

endpackage

// File: rtl/fir_bit_rate_div.sv
// Bit-rate divider: asserts tick on the last of every CLK_DIV enabled cycles.
// clr restarts the count so a new frame always begins on a full bit period.
module fir_bit_rate_div
    import fir_ser_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    // With CLK_DIV=1 cnt never leaves 0, so tick simply follows en.
    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_sample_serializer.sv
// Serial transmitter for FIR output samples: MSB-first on sdata, framed by sframe.
// Define FIR_SER_PARITY_EN to append an even-parity bit to every frame.
module fir_sample_serializer
    import fir_ser_pkg::*;
#(
    parameter int unsigned BW      = DEF_BW,
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [BW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          sdata,
    output logic          sframe,
    output logic          busy
);

    localparam int unsigned BCW = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    ser_state_e     state;
    ser_state_e     post_state;
    logic [BW-1:0]  shreg;
    logic [BCW-1:0] bit_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           accept;
    logic           div_en;
    logic           tick;
`ifdef FIR_SER_PARITY_EN
    logic           par_q;
`endif

    assign din_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = din_valid && din_ready;
    assign post_state = (GAP_CYC > 0) ? GAP : IDLE;

`ifdef FIR_SER_PARITY_EN
    assign div_en = (state == SHIFT) || (state == PARITY);
`else
    assign div_en = (state == SHIFT);
`endif

    fir_bit_rate_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .clr     (accept),
        .en      (div_en),
        .tick    (tick)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sdata   <= 1'b0;
            sframe  <= 1'b0;
`ifdef FIR_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= din;
                        bit_cnt <= BCW'(BW - 1);
                        state   <= SHIFT;
                        sframe  <= 1'b1;
                        sdata   <= din[BW-1];
`ifdef FIR_SER_PARITY_EN
                        par_q   <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (bit_cnt == '0) begin
`ifdef FIR_SER_PARITY_EN
                            state   <= PARITY;
                            sdata   <= par_q;
`else
                            state   <= post_state;
                            sframe  <= 1'b0;
                            sdata   <= 1'b0;
                            gap_cnt <= '0;
`endif
                        end else begin
                            // sdata shows the bit that becomes MSB after this shift
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                            sdata   <= shreg[BW-2];
                        end
                    end
                end
`ifdef FIR_SER_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state   <= post_state;
                        sframe  <= 1'b0;
                        sdata   <= 1'b0;
                        gap_cnt <= '0;
                    end
                end
`endif
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    sframe <= 1'b0;
                    sdata  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_serializer.sv
// Directed bench for fir_sample_serializer: CLK_DIV=1 and CLK_DIV=4 instances.
// Frame length follows FIR_SER_PARITY_EN (BW or BW+1 bits).
module tb_fir_sample_serializer;

`ifdef FIR_SER_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    logic       CLK;
    logic       RESET_N;
    logic [8:0] din1, din4;
    logic       dv1, dv4;
    logic       rdy1, rdy4, sdata1, sdata4, sframe1, sframe4, busy1, busy4;

    int n_checks = 0;
    int n_pass   = 0;

    fir_sample_serializer #(.BW(9), .CLK_DIV(1), .GAP_CYC(2)) dut1 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .din       (din1),
        .din_valid (dv1),
        .din_ready (rdy1),
        .sdata     (sdata1),
        .sframe    (sframe1),
        .busy      (busy1)
    );

    fir_sample_serializer #(.BW(9), .CLK_DIV(4), .GAP_CYC(2)) dut4 (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .din       (din4),
        .din_valid (dv4),
        .din_ready (rdy4),
        .sdata     (sdata4),
        .sframe    (sframe4),
        .busy      (busy4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected serial bit j of a frame carrying v: data MSB first, then even parity.
    function automatic logic exp_bit(input logic [8:0] v, input int j);
        if (j < 9) return v[8-j];
        return ^v;
    endfunction

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy1 && !busy4) begin
                done = 1;
                break;
            end
            @(negedge CLK);
        end
        n_checks++;
        if (!done) $display("FAIL wait_idle: busy1=%b busy4=%b after 200 cycles, want 0/0", busy1, busy4);
        else n_pass++;
    endtask

    task automatic send1(input logic [8:0] v);
        @(negedge CLK);
        din1 = v;
        dv1  = 1'b1;
        @(posedge CLK);
        #1 dv1 = 1'b0;
    endtask

    // Checks a full CLK_DIV=1 frame, the two gap cycles, and the return to IDLE.
    task automatic check_frame1(input string name, input logic [8:0] v);
        for (int i = 0; i < NB; i++) begin
            @(negedge CLK);
            n_checks++;
            if (sframe1 !== 1'b1 || sdata1 !== exp_bit(v, i))
                $display("FAIL %s bit%0d: sframe=%b sdata=%b, want 1 %b", name, i, sframe1, sdata1,
                         exp_bit(v, i));
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            n_checks++;
            if (sframe1 !== 1'b0 || sdata1 !== 1'b0 || busy1 !== 1'b1)
                $display("FAIL %s gap%0d: sframe=%b sdata=%b busy=%b, want 0 0 1", name, i, sframe1,
                         sdata1, busy1);
            else n_pass++;
        end
        @(negedge CLK);
        n_checks++;
        if (rdy1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL %s idle: din_ready=%b busy=%b, want 1 0", name, rdy1, busy1);
        else n_pass++;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            dv1 = ~dv1;
            dv4 = ~dv4;
            din1 = 9'h1FF;
            din4 = 9'h1FF;
            n_checks++;
            if ({sdata1, sframe1, busy1, sdata4, sframe4, busy4} !== 6'b0)
                $display("FAIL reset_outputs: s/f/b dut1=%b%b%b dut4=%b%b%b, want all 0", sdata1,
                         sframe1, busy1, sdata4, sframe4, busy4);
            else n_pass++;
        end
        dv1 = 1'b0;
        dv4 = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (rdy1 !== 1'b1 || rdy4 !== 1'b1 || busy1 !== 1'b0 || sframe1 !== 1'b0)
            $display("FAIL reset_release: rdy1=%b rdy4=%b busy1=%b sframe1=%b, want 1 1 0 0", rdy1, rdy4,
                     busy1, sframe1);
        else n_pass++;
    endtask

    task automatic test_div1_frame();
        wait_idle();
        send1(9'h1A5);
        check_frame1("div1_1A5", 9'h1A5);
    endtask

    task automatic test_div4_frame();
        wait_idle();
        @(negedge CLK);
        din4 = 9'h100;
        dv4  = 1'b1;
        @(posedge CLK);
        #1 dv4 = 1'b0;
        for (int i = 0; i < NB * 4; i++) begin
            @(negedge CLK);
            n_checks++;
            if (sframe4 !== 1'b1 || sdata4 !== exp_bit(9'h100, i / 4))
                $display("FAIL div4_100 cyc%0d: sframe=%b sdata=%b, want 1 %b", i, sframe4, sdata4,
                         exp_bit(9'h100, i / 4));
            else n_pass++;
        end
        @(negedge CLK);
        n_checks++;
        if (sframe4 !== 1'b0 || busy4 !== 1'b1)
            $display("FAIL div4_end: sframe=%b busy=%b, want 0 1", sframe4, busy4);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic       prev = 1'b0;
        int         rise[$];
        logic       f1[$];
        logic       f2[$];
        wait_idle();
        @(negedge CLK);
        din1 = 9'h0F0;
        dv1  = 1'b1;
        for (int i = 0; i <= 22; i++) begin
            @(negedge CLK);
            if (sframe1 && !prev) rise.push_back(i);
            if (sframe1 && rise.size() == 1) f1.push_back(sdata1);
            if (sframe1 && rise.size() == 2) f2.push_back(sdata1);
            prev = sframe1;
            if (i == 3) din1 = 9'h1FF;
            if (i == 5) begin
                n_checks++;
                if (rdy1 !== 1'b0) $display("FAIL b2b_ready_busy: din_ready=%b, want 0", rdy1);
                else n_pass++;
            end
        end
        dv1 = 1'b0;
        n_checks++;
        if (rise.size() != 2) $display("FAIL b2b_frames: got %0d frame starts, want 2", rise.size());
        else n_pass++;
        if (rise.size() == 2) begin
            n_checks++;
            if (rise[1] - rise[0] != 1 + NB + 2)
                $display("FAIL b2b_spacing: got %0d cycles, want %0d", rise[1] - rise[0], 1 + NB + 2);
            else n_pass++;
        end
        n_checks++;
        if (f1.size() != NB || f2.size() != NB)
            $display("FAIL b2b_len: frame1=%0d frame2=%0d bits, want %0d", f1.size(), f2.size(), NB);
        else n_pass++;
        for (int j = 0; j < NB && j < f1.size() && j < f2.size(); j++) begin
            n_checks++;
            if (f1[j] !== exp_bit(9'h0F0, j) || f2[j] !== exp_bit(9'h1FF, j))
                $display("FAIL b2b_bit%0d: got %b/%b, want %b/%b", j, f1[j], f2[j],
                         exp_bit(9'h0F0, j), exp_bit(9'h1FF, j));
            else n_pass++;
        end
    endtask

`ifdef FIR_SER_PARITY_EN
    task automatic test_parity();
        logic [8:0] vals [2];
        logic       par  [2];
        vals[0] = 9'h007; par[0] = 1'b1;
        vals[1] = 9'h003; par[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_idle();
            send1(vals[t]);
            repeat (9) @(negedge CLK);
            @(negedge CLK);
            n_checks++;
            if (sframe1 !== 1'b1 || sdata1 !== par[t])
                $display("FAIL parity_%03h: sframe=%b sdata=%b, want 1 %b", vals[t], sframe1, sdata1,
                         par[t]);
            else n_pass++;
            @(negedge CLK);
            n_checks++;
            if (sframe1 !== 1'b0)
                $display("FAIL parity_end_%03h: sframe=%b, want 0", vals[t], sframe1);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_midframe_reset();
        wait_idle();
        send1(9'h1FF);
        repeat (5) @(negedge CLK);
        n_checks++;
        if (sframe1 !== 1'b1 || sdata1 !== 1'b1)
            $display("FAIL midreset_pre: sframe=%b sdata=%b, want 1 1", sframe1, sdata1);
        else n_pass++;
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if (sframe1 !== 1'b0 || sdata1 !== 1'b0 || busy1 !== 1'b0)
            $display("FAIL midreset_async: sframe=%b sdata=%b busy=%b, want 0 0 0", sframe1, sdata1,
                     busy1);
        else n_pass++;
        #1 RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++;
            if (sframe1 !== 1'b0 || busy1 !== 1'b0 || rdy1 !== 1'b1)
                $display("FAIL midreset_idle%0d: sframe=%b busy=%b rdy=%b, want 0 0 1", i, sframe1,
                         busy1, rdy1);
            else n_pass++;
        end
        send1(9'h055);
        check_frame1("after_reset_055", 9'h055);
    endtask

    initial begin
        RESET_N = 1'b0;
        dv1 = 1'b0;
        dv4 = 1'b0;
        din1 = '0;
        din4 = '0;
        test_reset();
        test_div1_frame();
        test_div4_frame();
        test_back_to_back();
`ifdef FIR_SER_PARITY_EN
        test_parity();
`endif
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
